branch_issue_queue: RTL

Parametrised branch reservation station with DEPTH entries, CDB operand wakeup, oldest-first selection and mispredict flush. It sits between dispatch/rename and the branch execution unit. It holds branch/jump micro-ops until both operands are valid, then issues one per cycle into a registered output stage.

---
 rtl/branch_issue_queue_pkg.sv | 24 ++
 rtl/branch_issue_queue_slot.sv | 111 +++++++++++
 rtl/branch_issue_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_issue_queue_pkg.sv
// Shared constants and entry layout for the branch reservation station.
package branch_issue_queue_pkg;

    localparam int WIDTH_C   = 31;
    localparam int ROB_C     = 2;
    localparam int C_WIDTH_C = 7;
    localparam int DEPTH_C   = 4;

    typedef struct packed {
        logic                 valid;
        logic                 rdy1;
        logic                 rdy2;
        logic [WIDTH_C:0]     val1;
        logic [WIDTH_C:0]     val2;
        logic [ROB_C:0]       tag1;
        logic [ROB_C:0]       tag2;
        logic [ROB_C:0]       rob;
        logic [C_WIDTH_C:0]   ctrl;
        logic [WIDTH_C:0]     pred;
        logic [WIDTH_C:0]     target;
        logic [DEPTH_C-1:0]   age;
    } branch_rs_entry_t;

endpackage

// File: rtl/branch_issue_queue_slot.sv
// One reservation-station entry: storage, dispatch-time CDB bypass and operand wakeup.
module branch_rs_slot
    import branch_issue_queue_pkg::*;
#(
    parameter int WIDTH   = WIDTH_C,
    parameter int ROB     = ROB_C,
    parameter int C_WIDTH = C_WIDTH_C
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               flush,
    input  logic               alloc,
    input  logic               free,
    input  logic               ready1,
    input  logic               ready2,
    input  logic [WIDTH:0]     value1,
    input  logic [WIDTH:0]     value2,
    input  logic [ROB:0]       rob1,
    input  logic [ROB:0]       rob2,
    input  logic [ROB:0]       robInstr,
    input  logic [C_WIDTH:0]   branchControl,
    input  logic [WIDTH:0]     predictedPC,
    input  logic [WIDTH:0]     address,
    input  logic               cdbValid,
    input  logic [ROB:0]       cdbRob,
    input  logic [WIDTH:0]     cdbValue,
    output logic               valid,
    output logic               request,
    output logic [WIDTH:0]     val1,
    output logic [WIDTH:0]     val2,
    output logic [ROB:0]       rob,
    output logic [C_WIDTH:0]   ctrl,
    output logic [WIDTH:0]     pred,
    output logic [WIDTH:0]     target
);

    logic               valid_r;
    logic               rdy1_r;
    logic               rdy2_r;
    logic [WIDTH:0]     val1_r;
    logic [WIDTH:0]     val2_r;
    logic [ROB:0]       tag1_r;
    logic [ROB:0]       tag2_r;
    logic [ROB:0]       rob_r;
    logic [C_WIDTH:0]   ctrl_r;
    logic [WIDTH:0]     pred_r;
    logic [WIDTH:0]     target_r;

    logic hit1_s;
    logic hit2_s;
    logic wake1_s;
    logic wake2_s;

    assign hit1_s  = cdbValid && (cdbRob == rob1);
    assign hit2_s  = cdbValid && (cdbRob == rob2);
    assign wake1_s = cdbValid && valid_r && !rdy1_r && (tag1_r == cdbRob);
    assign wake2_s = cdbValid && valid_r && !rdy2_r && (tag2_r == cdbRob);

    // Entry state: allocation with bypass, release on issue, CDB wakeup
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            valid_r  <= 1'b0;
            rdy1_r   <= 1'b0;
            rdy2_r   <= 1'b0;
            val1_r   <= '0;
            val2_r   <= '0;
            tag1_r   <= '0;
            tag2_r   <= '0;
            rob_r    <= '0;
            ctrl_r   <= '0;
            pred_r   <= '0;
            target_r <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (alloc) begin
            valid_r  <= 1'b1;
            rdy1_r   <= ready1 || hit1_s;
            rdy2_r   <= ready2 || hit2_s;
            val1_r   <= ready1 ? value1 : cdbValue;
            val2_r   <= ready2 ? value2 : cdbValue;
            tag1_r   <= rob1;
            tag2_r   <= rob2;
            rob_r    <= robInstr;
            ctrl_r   <= branchControl;
            pred_r   <= predictedPC;
            target_r <= address;
        end else begin
            if (free) begin
                valid_r <= 1'b0;
            end
            if (wake1_s) begin
                rdy1_r <= 1'b1;
                val1_r <= cdbValue;
            end
            if (wake2_s) begin
                rdy2_r <= 1'b1;
                val2_r <= cdbValue;
            end
        end
    end

    assign valid   = valid_r;
    assign request = valid_r && rdy1_r && rdy2_r;
    assign val1    = val1_r;
    assign val2    = val2_r;
    assign rob     = rob_r;
    assign ctrl    = ctrl_r;
    assign pred    = pred_r;
    assign target  = target_r;

endmodule

// File: rtl/branch_issue_queue.sv
// Branch reservation station: slot array, age-matrix oldest-first select and registered issue stage.
module branch_issue_queue
    import branch_issue_queue_pkg::*;
#(
    parameter int WIDTH   = WIDTH_C,
    parameter int ROB     = ROB_C,
    parameter int C_WIDTH = C_WIDTH_C,
    parameter int DEPTH   = DEPTH_C
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  flush,
    input  logic                  write,
    input  logic                  ready1,
    input  logic                  ready2,
    input  logic signed [WIDTH:0] value1,
    input  logic signed [WIDTH:0] value2,
    input  logic [ROB:0]          rob1,
    input  logic [ROB:0]          rob2,
    input  logic [ROB:0]          robInstr,
    input  logic [C_WIDTH:0]      branchControl,
    input  logic [WIDTH:0]        predictedPC,
    input  logic [WIDTH:0]        address,
    input  logic                  cdbValid,
    input  logic [ROB:0]          cdbRob,
    input  logic signed [WIDTH:0] cdbValue,
    input  logic                  execute,
    output logic                  full,
    output logic [DEPTH-1:0]      busy,
    output logic                  issueValid,
    output logic signed [WIDTH:0] src1,
    output logic signed [WIDTH:0] src2,
    output logic [ROB:0]          instrRob,
    output logic [C_WIDTH:0]      instrInfo,
    output logic [WIDTH:0]        predictedAddress,
    output logic [WIDTH:0]        targetAddress
);

    logic [DEPTH-1:0] valid_s;
    logic [DEPTH-1:0] req_s;
    logic [DEPTH-1:0] free_vec_s;
    logic [DEPTH-1:0] alloc_oh_s;
    logic [DEPTH-1:0] grant_s;
    logic [DEPTH-1:0] release_oh_s;
    logic             accept_s;
    logic             issue_s;

    logic [WIDTH:0]   val1_s   [DEPTH];
    logic [WIDTH:0]   val2_s   [DEPTH];
    logic [ROB:0]     rob_s    [DEPTH];
    logic [C_WIDTH:0] ctrl_s   [DEPTH];
    logic [WIDTH:0]   pred_s   [DEPTH];
    logic [WIDTH:0]   target_s [DEPTH];

    logic [WIDTH:0]   sel_val1_s;
    logic [WIDTH:0]   sel_val2_s;
    logic [ROB:0]     sel_rob_s;
    logic [C_WIDTH:0] sel_ctrl_s;
    logic [WIDTH:0]   sel_pred_s;
    logic [WIDTH:0]   sel_target_s;

    logic [DEPTH-1:0] age_r [DEPTH];

    logic             issue_valid_r;
    logic [WIDTH:0]   src1_r;
    logic [WIDTH:0]   src2_r;
    logic [ROB:0]     instr_rob_r;
    logic [C_WIDTH:0] instr_info_r;
    logic [WIDTH:0]   pred_addr_r;
    logic [WIDTH:0]   target_addr_r;

    // Lowest free slot via the isolate-lowest-set-bit trick on the free vector
    assign free_vec_s   = ~valid_s;
    assign accept_s     = write && !full;
    assign alloc_oh_s   = accept_s ? (free_vec_s & (~free_vec_s + DEPTH'(1))) : '0;
    assign issue_s      = execute && (|grant_s);
    assign release_oh_s = issue_s ? grant_s : '0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        branch_rs_slot #(
            .WIDTH   (WIDTH),
            .ROB     (ROB),
            .C_WIDTH (C_WIDTH)
        ) u_slot (
            .clk           (clk),
            .clear         (clear),
            .flush         (flush),
            .alloc         (alloc_oh_s[g]),
            .free          (release_oh_s[g]),
            .ready1        (ready1),
            .ready2        (ready2),
            .value1        (value1),
            .value2        (value2),
            .rob1          (rob1),
            .rob2          (rob2),
            .robInstr      (robInstr),
            .branchControl (branchControl),
            .predictedPC   (predictedPC),
            .address       (address),
            .cdbValid      (cdbValid),
            .cdbRob        (cdbRob),
            .cdbValue      (cdbValue),
            .valid         (valid_s[g]),
            .request       (req_s[g]),
            .val1          (val1_s[g]),
            .val2          (val2_s[g]),
            .rob           (rob_s[g]),
            .ctrl          (ctrl_s[g]),
            .pred          (pred_s[g]),
            .target        (target_s[g])
        );
    end

    // Grant the requester that is older than every other requester
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            automatic logic win = req_s[i];
            for (int j = 0; j < DEPTH; j++) begin
                win = win && ((i == j) || !req_s[j] || age_r[i][j]);
            end
            grant_s[i] = win;
        end
    end

    // One-hot AND-OR mux of the granted entry's fields
    always_comb begin
        sel_val1_s   = '0;
        sel_val2_s   = '0;
        sel_rob_s    = '0;
        sel_ctrl_s   = '0;
        sel_pred_s   = '0;
        sel_target_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_val1_s   = sel_val1_s   | (val1_s[i]   & {(WIDTH+1){grant_s[i]}});
            sel_val2_s   = sel_val2_s   | (val2_s[i]   & {(WIDTH+1){grant_s[i]}});
            sel_rob_s    = sel_rob_s    | (rob_s[i]    & {(ROB+1){grant_s[i]}});
            sel_ctrl_s   = sel_ctrl_s   | (ctrl_s[i]   & {(C_WIDTH+1){grant_s[i]}});
            sel_pred_s   = sel_pred_s   | (pred_s[i]   & {(WIDTH+1){grant_s[i]}});
            sel_target_s = sel_target_s | (target_s[i] & {(WIDTH+1){grant_s[i]}});
        end
    end

    // Age matrix: a new entry is younger than everything currently resident
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_r[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc_oh_s[i]) begin
                        age_r[i][j] <= 1'b0;
                    end else if (alloc_oh_s[j] && valid_s[i]) begin
                        age_r[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    // Issue stage: loads only when the downstream unit accepts
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            issue_valid_r <= 1'b0;
            src1_r        <= '0;
            src2_r        <= '0;
            instr_rob_r   <= '0;
            instr_info_r  <= '0;
            pred_addr_r   <= '0;
            target_addr_r <= '0;
        end else if (flush) begin
            issue_valid_r <= 1'b0;
        end else if (execute) begin
            issue_valid_r <= |grant_s;
            if (|grant_s) begin
                src1_r        <= sel_val1_s;
                src2_r        <= sel_val2_s;
                instr_rob_r   <= sel_rob_s;
                instr_info_r  <= sel_ctrl_s;
                pred_addr_r   <= sel_pred_s;
                target_addr_r <= sel_target_s;
            end
        end
    end

    assign busy             = valid_s;
    assign full             = &valid_s;
    assign issueValid       = issue_valid_r;
    assign src1             = src1_r;
    assign src2             = src2_r;
    assign instrRob         = instr_rob_r;
    assign instrInfo        = instr_info_r;
    assign predictedAddress = pred_addr_r;
    assign targetAddress    = target_addr_r;

endmodule
